// File: rtl/s2p_deser.sv
// s2p_deser: serial-to-parallel word assembler with flush, idle-timeout abort, optional even parity (S2P_PARITY_EN).
// Latency: dout/dout_vld one cycle after the last frame bit is sampled.
// Backpressure: none; every sin_vld bit is consumed, flush and idle timeout drop a partial frame.
module s2p_deser #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_vld,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              frame_err
`ifdef S2P_PARITY_EN
  ,
  output logic              par_err
`endif
);

`ifdef S2P_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idle_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;

  // Shifting toward the far end means the first bit lands at its final position after DATA_W bits.
  always_comb begin
    shift_nxt = '0;
    if (LSB_FIRST)
      shift_nxt = (shift >> 1) | (DATA_W'(sin) << (DATA_W - 1));
    else
      shift_nxt = (shift << 1) | DATA_W'(sin);
  end

`ifdef S2P_PARITY_EN
  logic par_bad;
  assign par_bad = (^shift) ^ sin;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idle_cnt  <= '0;
      shift     <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef S2P_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
`ifdef S2P_PARITY_EN
      par_err   <= 1'b0;
`endif
      if (flush) begin
        state    <= IDLE;
        cnt      <= '0;
        idle_cnt <= '0;
        shift    <= '0;
        busy     <= 1'b0;
      end else if (sin_vld) begin
        idle_cnt <= '0;
        if (cnt == LAST_BIT) begin
          state    <= IDLE;
          cnt      <= '0;
          shift    <= '0;
          busy     <= 1'b0;
          dout_vld <= 1'b1;
`ifdef S2P_PARITY_EN
          // Final bit is parity; data is already complete in shift.
          dout     <= shift;
          par_err  <= par_bad;
`else
          dout     <= shift_nxt;
`endif
        end else begin
          state <= RECV;
          cnt   <= cnt + 1'b1;
          shift <= shift_nxt;
          busy  <= 1'b1;
        end
      end else if (TIMEOUT > 0 && state == RECV) begin
        if (idle_cnt == IDLE_LAST) begin
          state     <= IDLE;
          cnt       <= '0;
          idle_cnt  <= '0;
          shift     <= '0;
          busy      <= 1'b0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_s2p_deser.sv
// Directed bench for s2p_deser (DATA_W=8, LSB-first, TIMEOUT=4); parity cases compile in with S2P_PARITY_EN.
module tb_s2p_deser;

`ifdef S2P_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n, sin, sin_vld, flush;
  logic [7:0] dout;
  logic       dout_vld, busy, frame_err;
`ifdef S2P_PARITY_EN
  logic       par_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] last_word = 8'h00;

  s2p_deser #(.DATA_W(8), .LSB_FIRST(1'b1), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_vld   (sin_vld),
    .flush     (flush),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .busy      (busy),
    .frame_err (frame_err)
`ifdef S2P_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic step(input logic b, input logic v, input logic f);
    sin = b;
    sin_vld = v;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] frm(input logic [7:0] w);
    return {^w, w};
  endfunction

  // Sends frame bits lo..hi; f[8] is the parity bit when parity is built in.
  task automatic send_bits(input string tag, input logic [8:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(f[i], 1'b1, 1'b0);
      if (i == FB - 1) begin
        chk({tag, " vld"}, 32'(dout_vld), 32'd1);
        chk({tag, " dout"}, 32'(dout), 32'(f[7:0]));
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
`ifdef S2P_PARITY_EN
        chk({tag, " par_err"}, 32'(par_err), 32'(^f));
`endif
        last_word = f[7:0];
      end else begin
        chk({tag, " early_vld"}, 32'(dout_vld), 32'd0);
        chk({tag, " held"}, 32'(dout), 32'(last_word));
        chk({tag, " busy"}, 32'(busy), 32'd1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b0; sin_vld = 1'b0; flush = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst dout", 32'(dout), 32'h00);
    chk("rst vld", 32'(dout_vld), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // 0,0,1,1,1,0,1,1 LSB-first assembles to 8'hDC
    send_bits("c1", frm(8'hDC), 0, FB - 1);
    step(1'b0, 1'b0, 1'b0);
    chk("c1 pulse_1cyc", 32'(dout_vld), 32'd0);
    chk("c1 dout_hold", 32'(dout), 32'hDC);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    chk("idle no_timeout", 32'(frame_err), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);

    // Flush with a coincident bit drops the partial frame.
    send_bits("c4a", 9'h1FF, 0, 4);
    step(1'b1, 1'b1, 1'b1);
    chk("c4 flush vld", 32'(dout_vld), 32'd0);
    chk("c4 flush busy", 32'(busy), 32'd0);
    chk("c4 flush dout", 32'(dout), 32'hDC);
    send_bits("c4b", frm(8'h0F), 0, FB - 1);

    // Flush coincident with the last bit drops the whole frame.
    send_bits("c4c", frm(8'h66), 0, FB - 2);
    step(1'b0, 1'b1, 1'b1);
    chk("c4 flush_last vld", 32'(dout_vld), 32'd0);
    chk("c4 flush_last dout", 32'(dout), 32'h0F);
    chk("c4 flush_last busy", 32'(busy), 32'd0);

    // Back-to-back frames, no gap.
    send_bits("c2a", frm(8'hA5), 0, FB - 1);
    send_bits("c2b", frm(8'h3C), 0, FB - 1);

    // Three idle cycles mid-frame stay under the 4-cycle timeout.
    send_bits("c3a", frm(8'h81), 0, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("c3 gap vld", 32'(dout_vld), 32'd0);
      chk("c3 gap busy", 32'(busy), 32'd1);
      chk("c3 gap ferr", 32'(frame_err), 32'd0);
    end
    send_bits("c3b", frm(8'h81), 4, FB - 1);

    // Four idle cycles mid-frame abort it.
    send_bits("c5a", 9'h007, 0, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("c5 pre ferr", 32'(frame_err), 32'd0);
      chk("c5 pre busy", 32'(busy), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("c5 ferr", 32'(frame_err), 32'd1);
    chk("c5 busy", 32'(busy), 32'd0);
    chk("c5 vld", 32'(dout_vld), 32'd0);
    chk("c5 dout", 32'(dout), 32'h81);
    step(1'b0, 1'b0, 1'b0);
    chk("c5 ferr_1cyc", 32'(frame_err), 32'd0);

    // Reset mid-frame clears everything and the partial frame is lost.
    send_bits("c5b", 9'h007, 0, 2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("c5r dout", 32'(dout), 32'h00);
    chk("c5r vld", 32'(dout_vld), 32'd0);
    chk("c5r busy", 32'(busy), 32'd0);
    chk("c5r ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    last_word = 8'h00;
    send_bits("c5r frame", frm(8'h5A), 0, FB - 1);

`ifdef S2P_PARITY_EN
    send_bits("c6 good", {1'b1, 8'hDC}, 0, FB - 1);
    send_bits("c6 bad", {1'b0, 8'hDC}, 0, FB - 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
